// File: rtl/elim_pkg.sv
// elim_pkg: shared FSM encoding and size helpers for the elimination core and its unload reader
package elim_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int depth(input int n, input int l);
        return n * n / l;
    endfunction

    function automatic int row_words(input int n, input int l);
        return (n / l < 1) ? 1 : n / l;
    endfunction
endpackage

// File: rtl/elim_unload_skid.sv
// elim_unload_skid: 2-entry valid/ready skid buffer; d0 is always the head presented downstream
module elim_unload_skid #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   cnt
);
    logic         v0, v1, pop;
    logic [W-1:0] d0, d1;

    assign pop       = v0 && out_ready;
    assign out_valid = v0;
    assign out_data  = d0;
    assign cnt       = {1'b0, v0} + {1'b0, v1};

    // d1 may be loaded speculatively; v1 decides whether it is real
    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            d0 <= (pop || !v0) ? (v1 ? d1 : in_data) : d0;
            d1 <= push ? in_data : d1;
            v0 <= v1 || push || (v0 && !pop);
            v1 <= v1 ? (push || !pop) : (v0 && push && !pop);
        end
    end
endmodule

// File: rtl/elim_unload.sv
// elim_unload: streams the systemized matrix out of the elim memory after done_in rises.
// Define ELIM_UNLOAD_CHECKSUM_EN to append an XOR checksum beat after the last word.
module elim_unload import elim_pkg::*; #(
    parameter int N         = 64,
    parameter int L         = 32,
    parameter int DEPTH     = depth(N, L),
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int ROW_WORDS = row_words(N, L)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [L-1:0]      mem_rd_data,
    output logic [L-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_row_last,
    output logic              out_last,
    output logic              busy
);
    state_t            state;
    logic              done_q, pend, pend_rl, pend_last;
    logic              trig, last_addr, pop, rd_en, fin, push;
    logic [ADDR_W-1:0] addr, col;
    logic [1:0]        cnt;
    logic [L+1:0]      push_word, pop_word;

    assign trig        = done_in && !done_q && state == IDLE;
    assign last_addr   = addr == ADDR_W'(DEPTH - 1);
    assign pop         = out_valid && out_ready;
    // a slot freed by this cycle's pop counts as a credit, keeping 1 word/cycle
    assign rd_en       = state == ISSUE && (({1'b0, cnt} + {2'b0, pend}) < 3'd2 || pop);
    assign fin         = pop && out_last;
    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = addr;
    assign {out_row_last, out_last, out_data} = pop_word;

`ifdef ELIM_UNLOAD_CHECKSUM_EN
    logic [L-1:0] ck;
    logic         ck_pend;

    assign push      = pend || (ck_pend && (cnt != 2'd2 || pop));
    assign push_word = pend ? {pend_rl, 1'b0, mem_rd_data} : {2'b01, ck};

    always_ff @(posedge clk) begin
        if (rst || trig) begin
            ck      <= '0;
            ck_pend <= 1'b0;
        end else begin
            ck      <= pend ? ck ^ mem_rd_data : ck;
            ck_pend <= pend ? pend_last : ck_pend && !push;
        end
    end
`else
    assign push      = pend;
    assign push_word = {pend_rl, pend_last, mem_rd_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            pend      <= 1'b0;
            pend_rl   <= 1'b0;
            pend_last <= 1'b0;
            addr      <= '0;
            col       <= '0;
            busy      <= 1'b0;
        end else begin
            done_q    <= done_in;
            pend      <= rd_en;
            pend_rl   <= col == ADDR_W'(ROW_WORDS - 1);
            pend_last <= last_addr;
            if (trig) begin
                state <= ISSUE;
                busy  <= 1'b1;
                addr  <= '0;
                col   <= '0;
            end else if (rd_en) begin
                addr  <= last_addr ? addr : addr + ADDR_W'(1);
                col   <= (col == ADDR_W'(ROW_WORDS - 1)) ? '0 : col + ADDR_W'(1);
                state <= last_addr ? DRAIN : state;
            end else if (fin) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

    elim_unload_skid #(.W(L + 2)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .in_data   (push_word),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (pop_word),
        .cnt       (cnt)
    );
endmodule
